// File: rtl/tangram_pkg.sv
// Shared tangram definitions: direction indices, move FSM encoding,
// frame-counter width and small helpers.
package tangram_pkg;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  localparam int FCNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    HOLD   = 2'd2,
    REPEAT = 2'd3
  } move_state_t;

  typedef logic [FCNT_W-1:0] fcnt_t;

  function automatic fcnt_t fcnt_inc(input fcnt_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // A chord or no button at all is not a direction.
  function automatic logic dir_valid(input logic [3:0] d);
    return $onehot(d);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchronizer followed by a stability counter
// that copies the level out once it has held for DEB_CYCLES cycles.
module btn_debounce #(
  parameter int DEB_CYCLES = 400000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // sync1 != sync2 flags a change about to enter the synchronized level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sync1 != sync2) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_ctrl.sv
// Debounced, frame-aligned move pulses with hold-to-repeat.
// MOVE_ACCEL_EN: halve the repeat interval after 8 repeat pulses.
module move_ctrl
  import tangram_pkg::*;
#(
  parameter int DEB_CYCLES          = 400000,
  parameter int REPEAT_DELAY_FRAMES = 30,
  parameter int REPEAT_RATE_FRAMES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic [3:0] move_btn,
  output logic [3:0] move_pulse,
  output logic [3:0] held
);

  localparam fcnt_t DELAY = fcnt_t'(REPEAT_DELAY_FRAMES);
  localparam fcnt_t RATE  = fcnt_t'(REPEAT_RATE_FRAMES);

`ifdef MOVE_ACCEL_EN
  localparam int    FAST_I = (REPEAT_RATE_FRAMES / 2 < 1) ?
                             1 : REPEAT_RATE_FRAMES / 2;
  localparam fcnt_t FAST   = fcnt_t'(FAST_I);
`endif

  for (genvar i = 0; i < 4; i++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .btn  (move_btn[i]),
      .level(held[i])
    );
  end

  logic vsync_q;
  logic frame_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      frame_tick <= vsync_q & ~vsync;
    end
  end

  move_state_t state_q, state_n;
  logic [3:0]  dir_q, dir_n;
  fcnt_t       fcnt_q, fcnt_n;
  fcnt_t       fcnt_up;
  fcnt_t       interval;
  logic [3:0]  pulse_q, pulse_n;
  logic        dir_ok;

`ifdef MOVE_ACCEL_EN
  logic [3:0] rcnt_q, rcnt_n;
  logic       rpt_fire;
`endif

  assign dir_ok  = dir_valid(held);
  assign fcnt_up = fcnt_inc(fcnt_q);

`ifdef MOVE_ACCEL_EN
  assign interval = (rcnt_q >= 4'd8) ? FAST : RATE;
`else
  assign interval = RATE;
`endif

  always_comb begin
    state_n = state_q;
    dir_n   = dir_q;
    fcnt_n  = fcnt_q;
    pulse_n = '0;
`ifdef MOVE_ACCEL_EN
    rpt_fire = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (dir_ok) begin
          dir_n   = held;
          fcnt_n  = '0;
          state_n = ARMED;
        end
      end
      default: begin
        // Invalid direction is checked first so release beats a tick.
        if (!dir_ok) begin
          dir_n   = '0;
          fcnt_n  = '0;
          state_n = IDLE;
        end else if (held != dir_q) begin
          dir_n   = held;
          fcnt_n  = '0;
          state_n = ARMED;
        end else if (frame_tick) begin
          unique case (state_q)
            ARMED: begin
              pulse_n = dir_q;
              fcnt_n  = '0;
              state_n = HOLD;
            end
            HOLD: begin
              if (fcnt_up >= DELAY) begin
                pulse_n = dir_q;
                fcnt_n  = '0;
                state_n = REPEAT;
              end else begin
                fcnt_n = fcnt_up;
              end
            end
            REPEAT: begin
              if (fcnt_up >= interval) begin
                pulse_n = dir_q;
                fcnt_n  = '0;
`ifdef MOVE_ACCEL_EN
                rpt_fire = 1'b1;
`endif
              end else begin
                fcnt_n = fcnt_up;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= '0;
      fcnt_q  <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_n;
      dir_q   <= dir_n;
      fcnt_q  <= fcnt_n;
      pulse_q <= pulse_n;
    end
  end

`ifdef MOVE_ACCEL_EN
  always_comb begin
    rcnt_n = rcnt_q;
    if (state_n != REPEAT) begin
      rcnt_n = '0;
    end else if (rpt_fire && rcnt_q != 4'd8) begin
      rcnt_n = rcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt_q <= '0;
    end else begin
      rcnt_q <= rcnt_n;
    end
  end
`endif

  assign move_pulse = pulse_q;

endmodule

// File: tb/tb_move_ctrl.sv
// Scoreboard bench for move_ctrl: expected pulses (frame, value) are
// queued when buttons are driven and matched as pulses appear.
module tb_move_ctrl;

  localparam int DEB   = 8;
  localparam int DLY   = 3;
  localparam int RATE  = 2;
  localparam int FRAME = 100;
  localparam int PH    = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync = 1'b1;
  logic [3:0] move_btn;
  logic [3:0] move_pulse;
  logic [3:0] held;

  move_ctrl #(
    .DEB_CYCLES         (DEB),
    .REPEAT_DELAY_FRAMES(DLY),
    .REPEAT_RATE_FRAMES (RATE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .vsync     (vsync),
    .move_btn  (move_btn),
    .move_pulse(move_pulse),
    .held      (held)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         frame;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   frame_no = 0;
  int   frame_cyc = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int fr, input logic [3:0] v);
    exp_t e;
    e.frame = fr;
    e.val   = v;
    sb.push_back(e);
  endtask

  // Expected pulse frames for a hold armed at frame arm, held through
  // the pulse slot at offset last.
  task automatic push_hold(input int arm, input int last,
                           input logic [3:0] v);
    int t;
    int n;
    int step;
    push(arm, v);
    if (DLY <= last) begin
      push(arm + DLY, v);
      t = DLY;
      n = 0;
      while (1) begin
        step = RATE;
`ifdef MOVE_ACCEL_EN
        if (n >= 8) step = (RATE / 2 < 1) ? 1 : RATE / 2;
`endif
        t += step;
        if (t > last) break;
        push(arm + t, v);
        n++;
      end
    end
  endtask

  task automatic wait_pos(input int f, input int c);
    int k;
    k = 0;
    while (!(frame_no == f && frame_cyc == c)) begin
      @(negedge clk);
      k++;
      if (k > 30000) begin
        check("wait_timeout", k, 0);
        return;
      end
    end
  endtask

  // Frame generator: vsync low for the first 4 cycles of each frame.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (frame_cyc == FRAME - 1) begin
        frame_cyc = 0;
        frame_no++;
      end else begin
        frame_cyc++;
      end
      vsync = (frame_cyc < 4) ? 1'b0 : 1'b1;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (move_pulse !== 4'b0) begin
        if (sb.size() == 0) begin
          check("unexp_pulse", move_pulse, 0);
        end else begin
          e = sb.pop_front();
          check("p_val", move_pulse, e.val);
          check("p_frame", frame_no, e.frame);
          check("p_phase", frame_cyc, PH);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int         f;
    int         n;
    logic [3:0] acc;
    reset    = 1'b1;
    move_btn = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_held", held, 0);
    check("rst_pulse", move_pulse, 0);

    f = frame_no + 1;
    wait_pos(f, 20);
    acc = '0;
    for (int i = 0; i < 10; i++) begin
      move_btn[0] = ~move_btn[0];
      repeat (3) begin
        @(negedge clk);
        acc |= held;
      end
    end
    repeat (15) begin
      @(negedge clk);
      acc |= held;
    end
    check("bounce_held", acc, 0);

    f = frame_no + 1;
    wait_pos(f, 20);
    move_btn[2] = 1'b1;
    n = 0;
    while (!held[2] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("deb_latency", n, DEB + 2);
    check("press_held", held, 4'b0100);
    push(f + 1, 4'b0100);
    wait_pos(f + 1, 20);
    move_btn[2] = 1'b0;
    repeat (15) @(negedge clk);
    check("rel_held", held, 0);

    f = frame_no + 1;
    wait_pos(f, 20);
    move_btn[3] = 1'b1;
    push_hold(f + 1, 11, 4'b1000);
    wait_pos(f + 12, 20);
    move_btn[3] = 1'b0;

    f = frame_no + 1;
    wait_pos(f, 20);
    move_btn[1:0] = 2'b11;
    repeat (15) @(negedge clk);
    check("chord_held", held, 4'b0011);
    wait_pos(f + 2, 20);
    move_btn[1] = 1'b0;
    push(f + 3, 4'b0001);
    wait_pos(f + 3, 20);
    move_btn[0] = 1'b0;

    // held[1] falls on the same edge that registers the tick of f+10.
    f = frame_no + 1;
    wait_pos(f, 20);
    move_btn[1] = 1'b1;
    push_hold(f + 1, 7, 4'b0010);
    wait_pos(f + 9, FRAME - 9);
    move_btn[1] = 1'b0;
    wait_pos(f + 11, 50);
    check("tick_rel_held", held, 0);
    check("tick_rel_state", dut.state_q, 0);

    f = frame_no + 1;
    wait_pos(f, 20);
    move_btn[3] = 1'b1;
    push(f + 1, 4'b1000);
    wait_pos(f + 1, 50);
    reset = 1'b1;
    @(negedge clk);
    check("mr_held", held, 0);
    check("mr_pulse", move_pulse, 0);
    check("mr_state", dut.state_q, 0);
    reset = 1'b0;
    n = 0;
    while (!held[3] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mr_redeb", n, DEB + 2);
    push_hold(f + 2, 22, 4'b1000);
    wait_pos(f + 24, 20);
    move_btn[3] = 1'b0;

    wait_pos(frame_no + 2, 50);
    check("sb_empty", sb.size(), 0);
    check("end_held", held, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
